// File: rtl/button_events_pkg.sv
// button_events_pkg: shared FSM state type, counter type and default timing constants.
package button_events_pkg;
   localparam int CNT_BITS_DEF = 24;
   localparam int LONG_CYCLES_DEF = 12000000;
   localparam int REPEAT_CYCLES_DEF = 3000000;
   localparam int DCLICK_CYCLES_DEF = 4000000;
   typedef logic [1:0] state_bits_t;
   typedef enum state_bits_t {IDLE, PRESSED, REPEAT} state_t;
   typedef logic [CNT_BITS_DEF-1:0] cnt_t;
endpackage

// File: rtl/button_events_if.sv
// button_events_if: debounced button input and UI event outputs of one push-button.
interface button_events_if;
   logic btn_in;
   logic btn_valid;
   logic press;
   logic release_evt;
   logic long_press;
   logic repeat_evt;
   logic held;
   logic double_click;
   modport master (output btn_in, btn_valid,
                   input press, release_evt, long_press, repeat_evt, held, double_click);
   modport slave (input btn_in, btn_valid,
                  output press, release_evt, long_press, repeat_evt, held, double_click);
endinterface

// File: rtl/button_events_timer.sv
// event_timer: up-counter with clear/enable and terminal-count flag against a runtime limit.
module event_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         tc
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      cnt <= (rst || clr) ? '0 : en ? cnt + W'(1) : cnt;
   assign tc = en && (cnt == limit);
endmodule

// File: rtl/button_events.sv
// button_events: debounced level to press/release/long-press/repeat pulses.
// Double-click detection is compiled in with BUTTON_EVENTS_DCLICK_EN.
module button_events
   import button_events_pkg::*;
#(
   parameter int CNT_BITS = CNT_BITS_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
   parameter int DCLICK_CYCLES = DCLICK_CYCLES_DEF
) (
   input logic            clk,
   input logic            rst,
   button_events_if.slave bus
);
   localparam logic [CNT_BITS-1:0] LONG_LIM = CNT_BITS'(LONG_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] REP_LIM = CNT_BITS'(REPEAT_CYCLES - 1);
   state_t st, nxt;
   logic lvl, rise, fall, tc;
   logic press_d, rel_d, long_d, rpt_d;
   logic press_q, rel_q, long_q, rpt_q, held_q;
   assign rise = bus.btn_valid && bus.btn_in && !lvl;
   assign fall = bus.btn_valid && !bus.btn_in && lvl;
   // Held time keeps counting while btn_valid is low; only edges are gated.
   event_timer #(.W(CNT_BITS)) u_cnt (
      .clk(clk), .rst(rst), .clr(st == IDLE || tc), .en(st != IDLE),
      .limit(st == PRESSED ? LONG_LIM : REP_LIM), .tc(tc)
   );
   always_comb begin
      nxt = st;
      press_d = 1'b0;
      rel_d = 1'b0;
      long_d = 1'b0;
      rpt_d = 1'b0;
      if (st == IDLE) begin
         press_d = rise;
         nxt = rise ? PRESSED : IDLE;
      end else if (fall) begin
         rel_d = 1'b1;
         nxt = IDLE;
      end else if (tc) begin
         long_d = (st == PRESSED);
         rpt_d = (st == REPEAT);
         nxt = REPEAT;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         st <= IDLE;
         lvl <= 1'b0;
         {press_q, rel_q, long_q, rpt_q, held_q} <= '0;
      end else begin
         st <= nxt;
         lvl <= bus.btn_valid ? bus.btn_in : lvl;
         {press_q, rel_q, long_q, rpt_q} <= {press_d, rel_d, long_d, rpt_d};
         held_q <= (nxt != IDLE);
      end
   assign bus.press = press_q;
   assign bus.release_evt = rel_q;
   assign bus.long_press = long_q;
   assign bus.repeat_evt = rpt_q;
   assign bus.held = held_q;
`ifdef BUTTON_EVENTS_DCLICK_EN
   localparam logic [CNT_BITS-1:0] DC_LIM = CNT_BITS'(DCLICK_CYCLES - 1);
   logic armed, dc_press, gtc, dc_d, dc_q;
   event_timer #(.W(CNT_BITS)) u_gap (
      .clk(clk), .rst(rst), .clr(rel_d), .en(st == IDLE && armed),
      .limit(DC_LIM), .tc(gtc)
   );
   assign dc_d = (st == IDLE) && rise && armed;
   // The release that ends a double-click press must not re-arm.
   always_ff @(posedge clk)
      if (rst) begin
         armed <= 1'b0;
         dc_press <= 1'b0;
         dc_q <= 1'b0;
      end else begin
         dc_q <= dc_d;
         if (rel_d) begin
            armed <= !dc_press;
            dc_press <= 1'b0;
         end else if (dc_d) begin
            armed <= 1'b0;
            dc_press <= 1'b1;
         end else if (gtc) armed <= 1'b0;
      end
   assign bus.double_click = dc_q;
`else
   logic unused_dclick;
   assign unused_dclick = ^DCLICK_CYCLES;
   assign bus.double_click = 1'b0;
`endif
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed scenarios with a per-cycle expected-output scoreboard.
module tb_button_events;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0] sb[$];
   int compared = 0;
   int mismatched = 0;
   button_events_if bif ();
   button_events #(.LONG_CYCLES(10), .REPEAT_CYCLES(4), .DCLICK_CYCLES(6)) dut (
      .clk(clk), .rst(rst), .bus(bif)
   );
   always #5 clk = ~clk;
   function automatic logic [5:0] ev(input bit p, r, l, t, h, d);
      return {p, r, l, t, h, d};
   endfunction
   // Bit order: press, release, long_press, repeat, held, double_click.
   task automatic step(input string tag, input int e, input bit r, b, v, input logic [5:0] xp);
      logic [5:0] got, want;
      rst = r;
      bif.btn_in = b;
      bif.btn_valid = v;
      sb.push_back(xp);
      @(posedge clk);
      #1;
      got = {bif.press, bif.release_evt, bif.long_press, bif.repeat_evt, bif.held, bif.double_click};
      want = sb.pop_front();
      compared++;
      assert (got === want) else begin
         mismatched++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, e, got, want);
      end
   endtask
   task automatic rst_seq();
      step("reset", 0, 1'b1, 1'b0, 1'b1, 6'b0);
      step("reset", 0, 1'b1, 1'b0, 1'b1, 6'b0);
   endtask
   initial begin
      int e;
      bit b, v, r;
      bif.btn_in = 1'b0;
      bif.btn_valid = 1'b1;
      rst_seq();
      for (int c = 0; c <= 12; c++) begin
         e = c + 1;
         b = c >= 5 && c < 8;
         step("tap", e, 1'b0, b, 1'b1, ev(e == 6, e == 9, 0, 0, e >= 6 && e <= 8, 0));
      end
      rst_seq();
      for (int c = 0; c <= 34; c++) begin
         e = c + 1;
         b = c >= 5 && c < 30;
         step("long", e, 1'b0, b, 1'b1, ev(e == 6, e == 31, e == 16, e == 20 || e == 24 || e == 28, e >= 6 && e <= 30, 0));
      end
      rst_seq();
      for (int c = 0; c <= 15; c++) begin
         e = c + 1;
         v = !(c >= 5 && c <= 9);
         b = (c >= 6 && c <= 7) || c >= 12;
         step("gated", e, 1'b0, b, v, ev(e == 13, 0, 0, 0, e >= 13, 0));
      end
      rst_seq();
      for (int c = 0; c <= 20; c++) begin
         e = c + 1;
         b = c >= 5 && c < 15;
         step("simul", e, 1'b0, b, 1'b1, ev(e == 6, e == 16, 0, 0, e >= 6 && e <= 15, 0));
      end
      rst_seq();
      for (int c = 0; c <= 22; c++) begin
         e = c + 1;
         r = c == 19;
         b = c >= 5;
         step("midrst", e, r, b, 1'b1, ev(e == 6 || e == 21, 0, e == 16, 0, (e >= 6 && e <= 19) || e >= 21, 0));
      end
`ifdef BUTTON_EVENTS_DCLICK_EN
      rst_seq();
      for (int c = 0; c <= 22; c++) begin
         e = c + 1;
         b = (c >= 5 && c < 9) || (c >= 14 && c < 16) || (c >= 20 && c < 22);
         step("dclick", e, 1'b0, b, 1'b1, ev(e == 6 || e == 15 || e == 21, e == 10 || e == 17 || e == 23, 0, 0,
              (e >= 6 && e <= 9) || (e >= 15 && e <= 16) || (e >= 21 && e <= 22), e == 15));
      end
      rst_seq();
      for (int c = 0; c <= 20; c++) begin
         e = c + 1;
         b = (c >= 5 && c < 9) || c >= 18;
         step("dclick_late", e, 1'b0, b, 1'b1, ev(e == 6 || e == 19, e == 10, 0, 0, (e >= 6 && e <= 9) || e >= 19, 0));
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
